spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: ADDR_SIZE, default 8, width of the address/data payload byte.
REQ-002 Parameter: RD_WAIT, default 3, number of turnaround cycles between the last MOSI bit of a read-data frame and the first MISO sample.
REQ-003 Port: clk  input  1  system clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 Port: start  input  1  request a transaction; sampled only when busy=0.
REQ-006 Port: cmd  input  2  frame command: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
REQ-007 Port: din  input  ADDR_SIZE  payload byte sent after cmd.
REQ-008 Port: busy  output  1  high from the cycle after start acceptance until the done cycle inclusive.
REQ-009 Port: done  output  1  one-cycle pulse at transaction end.
REQ-010 Port: rdata  output  ADDR_SIZE  byte received on MISO for cmd=11.
REQ-011 Port: SS_n  output  1  active-low slave select.
REQ-012 Port: MOSI  output  1  serial data to slave, MSB first.
REQ-013 Port: MISO  input  1  serial data from slave, MSB first.

Function
REQ-014 All outputs shall be registered.
REQ-015 start with busy=0 shall latch cmd and din into an internal ADDR_SIZE+2-bit frame {cmd, din}; later changes on cmd/din shall have no effect on the transaction in progress.
REQ-016 start while busy=1 shall be ignored, with no queuing.
REQ-017 FSM states: IDLE, SELECT, CMD, SHIFT, WAIT, RECV, STOP.
REQ-018 IDLE: SS_n=1, MOSI=0; on accepted start go to SELECT.
REQ-019 SELECT (1 cycle): SS_n=0, MOSI=0; go to CMD.
REQ-020 CMD (1 cycle): SS_n=0, MOSI=frame[ADDR_SIZE+1], which is the slave's write/read select bit; go to SHIFT.
REQ-021 SHIFT (ADDR_SIZE+2 cycles): MOSI=frame bits from [ADDR_SIZE+1] down to [0], one per cycle; a 4-bit bit counter counts 0..ADDR_SIZE+1.
REQ-022 SHIFT exit: go to WAIT if cmd=11, otherwise go to STOP.
REQ-023 WAIT (RD_WAIT cycles): SS_n=0, MOSI=0.
REQ-024 RECV (ADDR_SIZE cycles): SS_n=0, MOSI=0; each cycle shift MISO into a receive register LSB-in, so the first sampled bit ends as the MSB.
REQ-025 STOP (1 cycle): SS_n=1, MOSI=0, done=1; go to IDLE.
REQ-026 STOP for cmd=11: load rdata with the receive register; for other cmds, rdata shall hold its previous value.
REQ-027 Frame length in clk cycles from start acceptance to done:
  - cmd 0x/10: ADDR_SIZE+5 (13 at default).
  - cmd 11: ADDR_SIZE+5+RD_WAIT+ADDR_SIZE (24 at default).
REQ-028 SS_n shall be high for at least 1 cycle between frames; back-to-back start asserted during the done cycle shall be ignored, and start is accepted in the next IDLE cycle.
REQ-029 Bit and wait counters shall be cleared on entry to SHIFT, WAIT and RECV; no counter shall wrap inside a state.
REQ-030 Unreachable state encodings shall go to IDLE with SS_n=1.

Reset
REQ-031 rst=1 at any time, including mid-frame, shall immediately force: state=IDLE, SS_n=1, MOSI=0, busy=0, done=0, rdata=0, all counters and the frame register cleared.
REQ-032 After rst deasserts, the first start shall be accepted on the first rising clk edge with rst=0.

Verification
REQ-033 Write-addr: start with cmd=00, din=0xA5 -> SS_n low for 12 cycles; MOSI CMD bit 0, then 0,0,1,0,1,0,0,1,0,1; done at cycle 13; rdata unchanged.
REQ-034 Read-data: cmd=11, din=0x00, MISO model drives 0x3C MSB-first starting 3 cycles after the last MOSI bit -> rdata=0x3C at done, which occurs at cycle 24.
REQ-035 Busy collision: second start with cmd=01, din=0xFF at cycle 5 of a cmd=10 frame -> ignored; only one done pulse; MOSI matches the first frame.
REQ-036 Mid-frame reset: rst pulsed at cycle 7 of a cmd=01 frame -> same-cycle SS_n=1, busy=0, MOSI=0; a new start afterwards produces a clean, full-length frame.
REQ-037 Back-to-back: start held high continuously -> each frame is separated by at least one SS_n=1 cycle; done pulses are exactly one cycle wide.
REQ-038 End-to-end with an SPI slave and RAM: write-addr 0x10, write-data 0x5A, read-addr 0x10, read-data -> rdata=0x5A.

Source files
------------

// File: rtl/spi_master.sv
// SPI master: sends a {cmd, din} frame MSB first and, for read-data frames, waits RD_WAIT
// cycles and then samples ADDR_SIZE bits from MISO into rdata.
module spi_master #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned RD_WAIT   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           cmd,
  input  logic [ADDR_SIZE-1:0] din,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] rdata,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int unsigned FW = ADDR_SIZE + 2;
  localparam int unsigned WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  typedef enum logic [2:0] {
    StIdle, StSelect, StCmd, StShift, StWait, StRecv, StStop
  } state_t;

  state_t               state_q;
  logic [FW-1:0]        frame_q;
  logic [3:0]           bit_cnt_q;
  logic [WW-1:0]        wait_cnt_q;
  // The final MISO bit goes straight into rdata, so only ADDR_SIZE-1 bits are held here.
  logic [ADDR_SIZE-2:0] rx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      rx_q       <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      SS_n       <= 1'b1;
      MOSI       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            frame_q <= {cmd, din};
            state_q <= StSelect;
            SS_n    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        StSelect: begin
          state_q <= StCmd;
          MOSI    <= frame_q[FW-1];
        end
        StCmd: begin
          state_q   <= StShift;
          bit_cnt_q <= '0;
          MOSI      <= frame_q[FW-1];
        end
        StShift: begin
          if (bit_cnt_q == 4'(FW - 1)) begin
            MOSI <= 1'b0;
            if (frame_q[FW-1:FW-2] == 2'b11) begin
              if (RD_WAIT == 0) begin
                state_q   <= StRecv;
                bit_cnt_q <= '0;
              end else begin
                state_q    <= StWait;
                wait_cnt_q <= '0;
              end
            end else begin
              state_q <= StStop;
              SS_n    <= 1'b1;
              done    <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            MOSI      <= frame_q[4'(ADDR_SIZE) - bit_cnt_q];
          end
        end
        StWait: begin
          if (wait_cnt_q == WW'(RD_WAIT - 1)) begin
            state_q   <= StRecv;
            bit_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + WW'(1);
          end
        end
        StRecv: begin
          rx_q <= {rx_q[ADDR_SIZE-3:0], MISO};
          if (bit_cnt_q == 4'(ADDR_SIZE - 1)) begin
            state_q <= StStop;
            SS_n    <= 1'b1;
            done    <= 1'b1;
            rdata   <= {rx_q, MISO};
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        StStop: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          SS_n    <= 1'b1;
          MOSI    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          SS_n    <= 1'b1;
          MOSI    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: table vectors, random frames against a cycle-list reference model,
// collision, mid-frame reset, back-to-back and slave-RAM round-trip sequences.
module tb_spi_master;

  localparam int AW = 8;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    cmd;
  logic [AW-1:0] din;
  logic          busy;
  logic          done;
  logic [AW-1:0] rdata;
  logic          ss_n;
  logic          mosi;
  logic          miso;

  always #5 clk = ~clk;

  spi_master #(
    .ADDR_SIZE(AW),
    .RD_WAIT  (RW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .cmd  (cmd),
    .din  (din),
    .busy (busy),
    .done (done),
    .rdata(rdata),
    .SS_n (ss_n),
    .MOSI (mosi),
    .MISO (miso)
  );

  int            checks = 0;
  int            errors = 0;
  string         cur_tag = "init";
  logic [AW-1:0] exp_rdata;
  logic [AW-1:0] ram [256];
  logic [AW-1:0] slave_addr;

  typedef struct {
    logic [1:0]    cmd;
    logic [AW-1:0] din;
    logic [AW-1:0] miso_byte;
    int            coll;
    int            len;
    logic [AW-1:0] rdata;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", cur_tag, name, act, exp);
    end
  endtask

  // Runs one frame starting from posedge+1 in an idle cycle; ends at posedge+1 two cycles
  // after done. Expected waveforms come from the frame's cycle list.
  task automatic run_frame(input logic [1:0] c, input logic [AW-1:0] d,
                           input logic [AW-1:0] mb, input int coll, output int done_at);
    logic [31:0]   ss_c, busy_c, done_c, mosi_c;
    logic [31:0]   ss_e, busy_e, done_e, mosi_e;
    logic [AW+1:0] fr;
    logic [AW+1:0] sfr;
    logic [AW+2:0] seq;
    logic [AW-1:0] rd_cap;
    int            len;
    int            rs;
    fr  = {c, d};
    seq = {c[1], fr};
    len = (c == 2'b11) ? (2 * AW + 5 + RW) : (AW + 5);
    rs  = AW + 5 + RW;
    ss_c = '0; busy_c = '0; done_c = '0; mosi_c = '0;
    ss_e = '0; busy_e = '0; done_e = '0; mosi_e = '0;
    done_at = 0;
    rd_cap  = 'x;
    start = 1'b1;
    cmd   = c;
    din   = d;
    @(posedge clk); #1;
    start = 1'b0;
    cmd   = 2'($urandom);
    din   = AW'($urandom);
    for (int k = 1; k <= len + 1; k++) begin
      if (c == 2'b11 && k >= rs && k < rs + AW) miso = mb[AW-1-(k-rs)];
      else miso = 1'($urandom);
      if (coll != 0 && k == coll) begin
        start = 1'b1;
        cmd   = 2'b01;
        din   = '1;
      end
      @(negedge clk);
      ss_c[k]   = ss_n;
      busy_c[k] = busy;
      done_c[k] = done;
      mosi_c[k] = mosi;
      if (done === 1'b1 && done_at == 0) begin
        done_at = k;
        rd_cap  = rdata;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int k = 1; k <= len + 1; k++) begin
      ss_e[k]   = (k >= len);
      busy_e[k] = (k <= len);
      done_e[k] = (k == len);
      mosi_e[k] = (k >= 2 && k <= AW + 4) ? seq[AW+4-k] : 1'b0;
    end
    if (c == 2'b11) exp_rdata = mb;
    check("ss_n", ss_c, ss_e);
    check("busy", busy_c, busy_e);
    check("done", done_c, done_e);
    check("mosi", mosi_c, mosi_e);
    check("rdata_at_done", {24'b0, rd_cap}, {24'b0, exp_rdata});
    check("rdata_after", {24'b0, rdata}, {24'b0, exp_rdata});
    // Slave side: recover the frame from the shifted MOSI bits.
    for (int j = 0; j < AW + 2; j++) sfr[AW+1-j] = mosi_c[3+j];
    case (sfr[AW+1:AW])
      2'b00, 2'b10: slave_addr = sfr[AW-1:0];
      2'b01:        ram[slave_addr] = sfr[AW-1:0];
      default:      ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            done_at;
    logic [1:0]    rc;
    logic [AW-1:0] rd;
    logic [AW-1:0] rm;
    int            dcount, dw, dmax, runs, rlen, bad_run;

    rst = 1'b1; start = 1'b0; cmd = '0; din = '0; miso = 1'b0;
    exp_rdata = '0; slave_addr = '0;
    for (int i = 0; i < 256; i++) ram[i] = '0;

    tbl[0] = '{2'b00, 8'hA5, 8'h00, 0, 13, 8'h00};
    tbl[1] = '{2'b11, 8'h00, 8'h3C, 0, 24, 8'h3C};
    tbl[2] = '{2'b10, 8'h10, 8'h00, 5, 13, 8'h3C};
    tbl[3] = '{2'b01, 8'h00, 8'hFF, 0, 13, 8'h3C};
    tbl[4] = '{2'b11, 8'hFF, 8'hC3, 0, 24, 8'hC3};
    tbl[5] = '{2'b00, 8'h5A, 8'h00, 0, 13, 8'hC3};
    tbl[6] = '{2'b11, 8'h81, 8'h01, 0, 24, 8'h01};

    repeat (2) @(posedge clk);
    #1;
    cur_tag = "reset";
    check("ss_n", {31'b0, ss_n}, 32'd1);
    check("mosi", {31'b0, mosi}, 32'd0);
    check("busy", {31'b0, busy}, 32'd0);
    check("done", {31'b0, done}, 32'd0);
    check("rdata", {24'b0, rdata}, 32'd0);
    rst = 1'b0;

    // First vector starts right after reset release, so its length also covers start-up.
    for (int i = 0; i < 7; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_frame(tbl[i].cmd, tbl[i].din, tbl[i].miso_byte, tbl[i].coll, done_at);
      check("len", done_at, tbl[i].len);
      check("rdata_tbl", {24'b0, rdata}, {24'b0, tbl[i].rdata});
    end

    for (int r = 0; r < 20; r++) begin
      rc = 2'($urandom);
      rd = AW'($urandom);
      rm = AW'($urandom);
      cur_tag = $sformatf("rand%0d", r);
      run_frame(rc, rd, rm, 0, done_at);
      check("len", done_at, (rc == 2'b11) ? (2 * AW + 5 + RW) : (AW + 5));
    end

    cur_tag = "preload";
    run_frame(2'b11, 8'h00, 8'hA7, 0, done_at);

    cur_tag = "midreset";
    start = 1'b1; cmd = 2'b01; din = 8'h5A;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("ss_n_before", {31'b0, ss_n}, 32'd0);
    rst = 1'b1;
    #1;
    check("ss_n", {31'b0, ss_n}, 32'd1);
    check("busy", {31'b0, busy}, 32'd0);
    check("mosi", {31'b0, mosi}, 32'd0);
    check("done", {31'b0, done}, 32'd0);
    check("rdata", {24'b0, rdata}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdata = '0;
    cur_tag = "after_reset";
    run_frame(2'b01, 8'h3C, 8'h00, 0, done_at);
    check("len", done_at, AW + 5);

    cur_tag = "b2b";
    dcount = 0; dw = 0; dmax = 0; runs = 0; rlen = 0; bad_run = 0;
    cmd = 2'b00; din = 8'h33; start = 1'b1;
    for (int j = 0; j < 44; j++) begin
      if (j == 42) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) begin
        dw++;
        if (dw > dmax) dmax = dw;
        if (dw == 1) dcount++;
      end else begin
        dw = 0;
      end
      if (ss_n === 1'b0) begin
        rlen++;
      end else begin
        if (rlen > 0) begin
          runs++;
          if (rlen != AW + 4) bad_run++;
        end
        rlen = 0;
      end
      @(posedge clk); #1;
    end
    check("done_count", dcount, 3);
    check("done_width", dmax, 1);
    check("ss_low_runs", runs, 3);
    check("ss_low_len", bad_run, 0);
    check("idle_busy", {31'b0, busy}, 32'd0);

    cur_tag = "e2e";
    run_frame(2'b00, 8'h10, 8'h00, 0, done_at);
    run_frame(2'b01, 8'h5A, 8'h00, 0, done_at);
    run_frame(2'b10, 8'h10, 8'h00, 0, done_at);
    run_frame(2'b11, 8'h00, ram[slave_addr], 0, done_at);
    check("rdata_ram", {24'b0, rdata}, 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
